// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the ALU sharing arbiter: ALU op codes and arbiter FSM states.
package alu_pkg;

    // Raw 3-bit ALU op code; unsupported codes pass through untouched.
    typedef logic [2:0] alucontrol_t;

    localparam alucontrol_t ALU_AND = 3'b000;
    localparam alucontrol_t ALU_OR  = 3'b001;
    localparam alucontrol_t ALU_ADD = 3'b010;
    localparam alucontrol_t ALU_SUB = 3'b110;
    localparam alucontrol_t ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_grant.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr,
// wrapping around past the top index.
module rr_grant #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any_req
);

    // Requester index visited at each search offset, (rr_ptr + offset) mod N_REQ.
    logic [ID_W:0]   sum_w [N_REQ];
    logic [ID_W-1:0] idx_w [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_order
            assign sum_w[gi] = {1'b0, rr_ptr} + (ID_W+1)'(gi);
            assign idx_w[gi] = (sum_w[gi] >= (ID_W+1)'(N_REQ))
                             ? ID_W'(sum_w[gi] - (ID_W+1)'(N_REQ))
                             : sum_w[gi][ID_W-1:0];
        end
    endgenerate

    // Walk the rotated order and stop at the first asserted request.
    always_comb begin
        any_req   = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any_req && req[idx_w[i]]) begin
                any_req   = 1'b1;
                grant_idx = idx_w[i];
            end
        end
    end

    // One-hot form of the chosen index.
    always_comb begin
        grant = '0;
        if (any_req) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between N_REQ requesters. One operation
// in flight: grant (IDLE) -> drive ALU (EXEC) -> hold response until taken (RESP).
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 32,
    parameter int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ-1:0][DATA_W-1:0]  req_operand1,
    input  logic [N_REQ-1:0][DATA_W-1:0]  req_operand2,
    input  logic [N_REQ-1:0][2:0]         req_alucontrol,
    output logic [N_REQ-1:0]              rsp_valid,
    input  logic [N_REQ-1:0]              rsp_ready,
    output logic [DATA_W-1:0]             rsp_result,
    output logic                          rsp_zero,
    output logic [DATA_W-1:0]             alu_operand1,
    output logic [DATA_W-1:0]             alu_operand2,
    output logic [2:0]                    alu_alucontrol,
    input  logic [DATA_W-1:0]             alu_result,
    input  logic                          alu_zero,
    output logic                          busy
);

    arb_state_t        state_reg;
    logic [ID_W-1:0]   rr_ptr_reg;
    logic [ID_W-1:0]   id_reg;
    logic [DATA_W-1:0] op1_reg;
    logic [DATA_W-1:0] op2_reg;
    alucontrol_t       ctl_reg;
    logic [DATA_W-1:0] result_reg;
    logic              zero_reg;

    logic [N_REQ-1:0]  grant_w;
    logic [ID_W-1:0]   grant_idx_w;
    logic              any_w;
    logic [ID_W-1:0]   rr_ptr_next;
    logic              rsp_accept_w;

    rr_grant #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_grant (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_reg),
        .grant     (grant_w),
        .grant_idx (grant_idx_w),
        .any_req   (any_w)
    );

    // The winner gets the lowest priority on the next search.
    assign rr_ptr_next = (grant_idx_w == ID_W'(N_REQ - 1)) ? '0 : grant_idx_w + ID_W'(1);

    // Only the owner's rsp_ready can complete the response.
    assign rsp_accept_w = rsp_ready[id_reg];

    // Requests are only accepted in IDLE and never while reset is held.
    assign req_ready = (reset_n && (state_reg == IDLE)) ? grant_w : '0;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rsp_valid
            assign rsp_valid[gi] = (state_reg == RESP) && (id_reg == ID_W'(gi));
        end
    endgenerate

    assign busy           = (state_reg != IDLE);
    assign rsp_result     = result_reg;
    assign rsp_zero       = zero_reg;
    assign alu_operand1   = op1_reg;
    assign alu_operand2   = op2_reg;
    assign alu_alucontrol = ctl_reg;

    // Arbitration FSM: latch winner's operands, capture ALU output, hold response.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= '0;
            id_reg     <= '0;
            op1_reg    <= '0;
            op2_reg    <= '0;
            ctl_reg    <= '0;
            result_reg <= '0;
            zero_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_w) begin
                        id_reg     <= grant_idx_w;
                        op1_reg    <= req_operand1[grant_idx_w];
                        op2_reg    <= req_operand2[grant_idx_w];
                        ctl_reg    <= req_alucontrol[grant_idx_w];
                        rr_ptr_reg <= rr_ptr_next;
                        state_reg  <= EXEC;
                    end
                end
                EXEC: begin
                    result_reg <= alu_result;
                    zero_reg   <= alu_zero;
                    state_reg  <= RESP;
                end
                RESP: begin
                    if (rsp_accept_w) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter with three requesters: directed scenarios with
// literal expectations plus a randomized run checked every cycle against a
// transaction-level model.
module tb_alu_share_arbiter;

    localparam int N = 3;
    localparam int W = 32;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic [N-1:0]          req_valid = '0;
    logic [N-1:0]          req_ready;
    logic [N-1:0][W-1:0]   req_operand1 = '0;
    logic [N-1:0][W-1:0]   req_operand2 = '0;
    logic [N-1:0][2:0]     req_alucontrol = '0;
    logic [N-1:0]          rsp_valid;
    logic [N-1:0]          rsp_ready = '0;
    logic [W-1:0]          rsp_result;
    logic                  rsp_zero;
    logic [W-1:0]          alu_operand1;
    logic [W-1:0]          alu_operand2;
    logic [2:0]            alu_alucontrol;
    logic [W-1:0]          alu_result;
    logic                  alu_zero;
    logic                  busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(
        .N_REQ  (N),
        .DATA_W (W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_operand1   (req_operand1),
        .req_operand2   (req_operand2),
        .req_alucontrol (req_alucontrol),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_result     (rsp_result),
        .rsp_zero       (rsp_zero),
        .alu_operand1   (alu_operand1),
        .alu_operand2   (alu_operand2),
        .alu_alucontrol (alu_alucontrol),
        .alu_result     (alu_result),
        .alu_zero       (alu_zero),
        .busy           (busy)
    );

    // External shared ALU
    function automatic logic [W-1:0] alu_fn(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] c);
        case (c)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_operand1, alu_operand2, alu_alucontrol);
    assign alu_zero   = (alu_result == '0);

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick(logic [N-1:0] v, int start);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic int idx_of(logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    // ---------------- transaction-level model ----------------
    bit          started = 1'b0;
    bit          have_op = 1'b0;
    int          acc_n = 0;
    int          owner = 0;
    int          next_start = 0;
    int          ncyc = 0;
    logic [W-1:0] m_op1 = '0;
    logic [W-1:0] m_op2 = '0;
    logic [2:0]   m_ctl = '0;

    always @(posedge clk) started <= 1'b1;

    always @(negedge clk) begin : model_check
        logic [N-1:0] e_rdy;
        logic [N-1:0] e_rv;
        logic [W-1:0] e_res;
        int           g;
        bit           rv_on;
        rv_on = have_op && (ncyc >= acc_n + 2);
        if (started) begin
            e_rdy = '0;
            e_rv  = '0;
            if (!have_op && reset_n) begin
                g = pick(req_valid, next_start);
                if (g >= 0) e_rdy[g] = 1'b1;
            end
            if (rv_on) e_rv[owner] = 1'b1;
            chk("req_ready", req_ready, e_rdy);
            chk("rsp_valid", rsp_valid, e_rv);
            chk("busy", busy, have_op);
            chk("alu_operand1", alu_operand1, m_op1);
            chk("alu_operand2", alu_operand2, m_op2);
            chk("alu_alucontrol", alu_alucontrol, m_ctl);
            if (rv_on) begin
                e_res = alu_fn(m_op1, m_op2, m_ctl);
                chk("rsp_result", rsp_result, e_res);
                chk("rsp_zero", rsp_zero, (e_res == '0));
            end
        end
        // what the coming edge does
        if (!reset_n) begin
            have_op    = 1'b0;
            next_start = 0;
            m_op1      = '0;
            m_op2      = '0;
            m_ctl      = '0;
        end else if (!have_op) begin
            g = pick(req_valid, next_start);
            if (g >= 0) begin
                have_op    = 1'b1;
                acc_n      = ncyc;
                owner      = g;
                m_op1      = req_operand1[g];
                m_op2      = req_operand2[g];
                m_ctl      = req_alucontrol[g];
                next_start = (g + 1) % N;
            end
        end else if (rv_on && rsp_ready[owner]) begin
            have_op = 1'b0;
        end
        ncyc++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(int idx, logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op,
                         logic [W-1:0] er, logic ez, int bp);
        int  n;
        bit  ok;
        req_valid[idx]      = 1'b1;
        req_operand1[idx]   = a;
        req_operand2[idx]   = b;
        req_alucontrol[idx] = op;
        ok = 1'b0;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[idx]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("grant_seen", ok, 1);
        tick();
        req_valid[idx] = 1'b0;
        ok = 1'b0;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (rsp_valid[idx]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rsp_seen", ok, 1);
        chk("rsp_latency", n, 2);
        chk("rsp_result_lit", rsp_result, er);
        chk("rsp_zero_lit", rsp_zero, ez);
        repeat (bp) tick();
        chk("held_valid_lit", rsp_valid[idx], 1);
        rsp_ready[idx] = 1'b1;
        tick();
        rsp_ready[idx] = 1'b0;
        $display("op req%0d ctl=%b a=%0h b=%0h -> result=%0h zero=%0b", idx, op, a, b, er, ez);
    endtask

    initial begin : stim
        int          gseq[$];
        int          rid[$];
        logic [W-1:0] rres[$];
        int          exp_id[4];
        logic [W-1:0] exp_res[4];
        logic [N-1:0] rdy;
        bit          seen;

        repeat (3) tick();
        chk("reset_req_ready", req_ready, 0);
        chk("reset_busy", busy, 0);
        reset_n = 1'b1;
        tick();

        do_op(0, 32'd5, 32'd7, 3'b010, 32'd12, 1'b0, 1);
        do_op(1, 32'd9, 32'd9, 3'b110, 32'd0, 1'b1, 1);
        do_op(2, 32'd100, 32'd23, 3'b010, 32'd123, 1'b0, 4);
        do_op(0, 32'hFFFF_FFFF, 32'd0, 3'b011, 32'd0, 1'b1, 2);

        // contention after reset
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        req_valid[0] = 1'b1; req_operand1[0] = 32'd1;    req_operand2[0] = 32'd1;    req_alucontrol[0] = 3'b010;
        req_valid[1] = 1'b1; req_operand1[1] = 32'hF0;   req_operand2[1] = 32'h0F;   req_alucontrol[1] = 3'b001;
        rsp_ready = '1;
        for (int n = 0; n < 60 && rid.size() < 4; n++) begin
            @(negedge clk);
            if (req_ready != '0) gseq.push_back(idx_of(req_ready));
            if (rsp_valid != '0) begin
                rid.push_back(idx_of(rsp_valid));
                rres.push_back(rsp_result);
            end
        end
        tick();
        req_valid = '0;
        rsp_ready = '0;
        exp_id  = '{0, 1, 0, 1};
        exp_res = '{32'd2, 32'hFF, 32'd2, 32'hFF};
        chk("contention_rsp_count", rid.size(), 4);
        chk("contention_grant_count_ok", (gseq.size() >= 4), 1);
        for (int k = 0; k < 4; k++) begin
            if (k < rid.size()) begin
                chk("contention_rsp_id", rid[k], exp_id[k]);
                chk("contention_rsp_result", rres[k], exp_res[k]);
                $display("contention rsp %0d: req%0d result=%0h", k, rid[k], rres[k]);
            end
            if (k < gseq.size()) chk("contention_grant", gseq[k], exp_id[k]);
        end

        // reset during EXEC of req1 SLT 3<4
        req_valid[1] = 1'b1; req_operand1[1] = 32'd3; req_operand2[1] = 32'd4; req_alucontrol[1] = 3'b111;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[1]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("slt_grant_seen", seen, 1);
        tick();
        req_valid[1] = 1'b0;
        reset_n      = 1'b0;
        seen         = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (rsp_valid != '0) seen = 1'b1;
            if (n < 2) tick();
        end
        chk("reset_drop_no_rsp", seen, 0);
        chk("reset_alu_operand1", alu_operand1, 0);
        chk("reset_alu_alucontrol", alu_alucontrol, 0);
        chk("reset_busy_mid", busy, 0);
        tick();
        reset_n = 1'b1;
        req_valid[1] = 1'b1; req_operand1[1] = 32'd3; req_operand2[1] = 32'd4; req_alucontrol[1] = 3'b111;
        req_valid[2] = 1'b1; req_operand1[2] = 32'd8; req_operand2[2] = 32'd8; req_alucontrol[2] = 3'b000;
        @(negedge clk);
        chk("after_reset_grant_from_0", req_ready, 3'b010);
        tick();
        req_valid = '0;
        rsp_ready = '1;
        repeat (4) tick();
        rsp_ready = '0;
        $display("reset mid-op scenario done");

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rdy = req_ready;
            tick();
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && rdy[i]) begin
                    req_valid[i] = ($urandom_range(0, 1) == 1);
                end else if (!req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) == 0);
                end else begin
                    continue;
                end
                if ($urandom_range(0, 3) == 0) begin
                    req_operand1[i] = 32'($urandom_range(0, 3));
                    req_operand2[i] = 32'($urandom_range(0, 3));
                end else begin
                    req_operand1[i] = $urandom;
                    req_operand2[i] = $urandom;
                end
                req_alucontrol[i] = 3'($urandom_range(0, 7));
            end
            rsp_ready = N'($urandom_range(0, (1 << N) - 1));
            reset_n   = ($urandom_range(0, 99) != 0);
        end
        req_valid = '0;
        reset_n   = 1'b1;
        rsp_ready = '1;
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational 32-bit ALU between N_REQ requesters, such as the main datapath, the branch-compare unit and the address-generation helper.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The block round-robin arbitrates, registers the winning operands, drives the ALU for one cycle and captures result/zero.
- It holds the response until the owning requester accepts it. One operation is in flight at a time.

Parameters:
N_REQ, 2, number of requesters (2..8)
DATA_W, 32, operand/result width
ID_W, $clog2(N_REQ) (min 1), requester index width

Ports:
clk  input  1  clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
req_valid  input  N_REQ  per-requester request valid
req_ready  output  N_REQ  per-requester request accept; one-hot or zero
req_operand1  input  N_REQ x DATA_W  per-requester operand1
req_operand2  input  N_REQ x DATA_W  per-requester operand2
req_alucontrol  input  N_REQ x 3  per-requester ALU op code
rsp_valid  output  N_REQ  per-requester response valid; one-hot or zero
rsp_ready  input  N_REQ  per-requester response accept
rsp_result  output  DATA_W  captured ALU result, shared bus, qualified by rsp_valid
rsp_zero  output  1  captured ALU zero flag
alu_operand1  output  DATA_W  to shared ALU
alu_operand2  output  DATA_W  to shared ALU
alu_alucontrol  output  3  to shared ALU
alu_result  input  DATA_W  from shared ALU (combinational)
alu_zero  input  1  from shared ALU
busy  output  1  high in EXEC or RESP

Behaviour:
- One clock (clk). Reset is synchronous, active-low (reset_n); it is sampled only on the rising edge.
- While reset_n=0 at an edge:
  - state=IDLE and rr_ptr=0.
  - Operand/op/result/zero/id registers are cleared to 0.
  - All req_ready=0, all rsp_valid=0 and busy=0.
  - The alu_* outputs are 0 (alucontrol=3'b000).
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = first asserted req_valid searching from index rr_ptr upward, with wrap-around.
  - req_ready[grant]=1 combinationally; all other req_ready bits are 0.
  - If any valid at the edge: latch that requester's operand1/operand2/alucontrol and grant id, set rr_ptr=(grant+1) mod N_REQ, go to EXEC.
  - If no valid: stay in IDLE and keep rr_ptr unchanged.
- EXEC (exactly 1 cycle):
  - The alu_* outputs present the latched registers.
  - At the edge, capture alu_result/alu_zero into rsp registers and go to RESP.
- RESP:
  - rsp_valid[id]=1; rsp_result and rsp_zero are stable.
  - On rsp_ready[id]=1 at an edge, go to IDLE.
  - rsp_ready of non-owning requesters is ignored.
- Latency and throughput:
  - Request accepted at edge N gives rsp_valid high from cycle N+2.
  - Minimum 3 cycles per operation.
  - A new grant can happen no earlier than the cycle after the response handshake.
- req_ready is 0 outside IDLE. A requester must hold valid and payload until ready; a valid dropped before grant is never served.
- alu_* outputs always reflect the operand/op registers. Those registers keep their values after EXEC until the next grant.
- Op codes pass through unmodified. Unsupported codes (e.g. 3'b011) produce whatever the ALU returns (result 0, zero 1); there is no error flag.
- Simultaneous requests: strict round-robin. A requester that was just granted is last priority next time, so there is no starvation (each waits ≤ N_REQ-1 grants).
- A requester whose rsp is pending may raise a new req_valid; it is considered only after returning to IDLE.
- Reset in EXEC or RESP drops the in-flight operation without a response; the next grant starts from index 0.
- rsp_result/rsp_zero hold their last value after handshake; they are meaningful only with rsp_valid.

Decomposition:
- Shared package alu_pkg:
  - alucontrol_t (3-bit) with constants ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SUB=110, ALU_SLT=111.
  - arb_state_t enum {IDLE, EXEC, RESP}.
- One sub-module, rr_grant: combinational round-robin priority picker (inputs req vector and rr_ptr; outputs grant one-hot, grant index and any).
- The shared ALU itself is instantiated at the top level, not inside this block.

Test Plan:
- Single ADD: req0 operand1=5, operand2=7, op 010 at cycle N -> rsp_valid[0] at N+2, result=12, zero=0; req_ready[1] never high.
- SUB to zero: req1 operand1=9, operand2=9, op 110 -> rsp_valid[1], result=0, zero=1; rsp_valid[0] stays 0.
- Contention after reset: req0 ADD 1+1 and req1 OR 0xF0|0x0F both valid -> req0 served first (result 2), then req1 (0xFF). Repeat with both held -> grants alternate 0,1,0,1.
- Backpressure: rsp_ready[0]=0 for 4 cycles -> rsp_valid[0], result and zero are stable, busy=1, req_ready all 0. Raise rsp_ready -> IDLE next cycle.
- Reset mid-op: reset_n=0 during EXEC of req1 SLT 3<4 -> no rsp_valid ever for that op, all outputs 0. After release, req1 alone is granted with rr_ptr=0 search.
- Unsupported op 3'b011 with operand1=0xFFFFFFFF -> result=0, zero=1, normal handshake.
